fir_wb_master_param: RTL and testbench

- Parametrised Wishbone (classic, single-transfer) master that drives a FIR slave.
- After reset it loads N_TAPS coefficients, then streams samples: write a sample, wait a programmable gap, read the result back.
- Unlike the fixed 4-tap master, it adds:
  - a runtime-writable coefficient table;
  - on-demand coefficient reload;
  - a ready/valid input handshake;
  - an error flag.
- It sits between the top-level sample stream and the FIR Wishbone slave.

---
 rtl/fir_wb_master_param.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_fir_wb_master_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_wb_master_param.sv
// fir_wb_master_param
// -------------------
// Wishbone classic master that drives a FIR slave. It has one single-transfer
// sequence for each job:
//   - After reset it writes the N_TAPS entries of a local coefficient table
//     to slave addresses 0..N_TAPS-1.
//   - It accepts one sample through a ready/valid handshake and writes it to
//     address N_TAPS.
//   - It idles WAIT_CYCLES cycles, then reads the result from address N_TAPS+1.
//   - It presents the result as a one-cycle strobe.
// The table can be rewritten at any time (coef_we). A coef_reload pulse
// queues a full re-send of the table. The re-send starts only when the
// master is idle, so a sample transaction that is in flight completes first.
//
// Optional build macro: FIR_WB_ACK_TIMEOUT_EN
//   When it is defined, an ack watchdog aborts any strobe that is held
//   TIMEOUT_CYCLES cycles without ack, and sets the sticky err flag.
//   When it is undefined, the master waits for ack forever and err stays 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data_in/_valid    sample stream from top; data_in_ready = accept
//   data_out/_valid   result from slave, one-cycle strobe
//   coef_we/idx/data  local coefficient table write port
//   coef_reload       pulse: re-send whole table to slave
//   busy              high except while waiting for input
//   err, err_clr      sticky error flag and its clear
//   adr_o, dat_o, dat_i, we_o, stb_o, cyc_o, ack_i   Wishbone master side

module fir_wb_master_param #(
  parameter int N_TAPS         = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int WAIT_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  coef_we,
  input  logic [IDX_W-1:0]      coef_idx,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic                  coef_reload,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i
);

  localparam logic [2:0] ST_LOAD_COEFF  = 3'd0;
  localparam logic [2:0] ST_WAIT_INPUT  = 3'd1;
  localparam logic [2:0] ST_SEND_SAMPLE = 3'd2;
  localparam logic [2:0] ST_WAIT_RESULT = 3'd3;
  localparam logic [2:0] ST_READ_RESULT = 3'd4;

  localparam logic [IDX_W-1:0]      LAST_IDX_C   = IDX_W'(N_TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] SAMPLE_ADR_C = ADDR_WIDTH'(N_TAPS);
  localparam logic [ADDR_WIDTH-1:0] RESULT_ADR_C = ADDR_WIDTH'(N_TAPS + 1);
  localparam logic [7:0]            WAIT_LOAD_C  = 8'(WAIT_CYCLES);

  logic [2:0]            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [7:0]            wait_cnt_r;
  logic [DATA_WIDTH-1:0] coef_r [N_TAPS];
  logic                  reload_pending_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  we_r;
  logic                  stb_r;
  logic                  cyc_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_out_valid_r;
  logic                  data_in_ready_r;
  logic                  busy_r;
  logic                  err_r;

  logic                  timeout_s;
  logic                  xfer_done_s;
  logic                  load_done_s;

`ifdef FIR_WB_ACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT_C = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog fires in the cycle that completes TIMEOUT_CYCLES strobe cycles without ack
  always_comb begin
    timeout_s = 1'b0;
    if (stb_r && !ack_i && (wd_cnt_r == WD_LIMIT_C)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Watchdog counter: held at zero while the strobe is low, so every strobe rise starts from 0
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
    end else if (!stb_r) begin
      wd_cnt_r <= '0;
    end else if (!ack_i) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end
`else
  // Without the watchdog no transfer is ever aborted
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Transfer completion (ack or abort) and end-of-table detection
  always_comb begin
    xfer_done_s = stb_r && (ack_i || timeout_s);
    load_done_s = 1'b0;
    if ((state_r == ST_LOAD_COEFF) && xfer_done_s && (idx_r == LAST_IDX_C)) begin
      load_done_s = 1'b1;
    end else begin
      load_done_s = 1'b0;
    end
  end

  // Local coefficient table: reset pattern i+1, written by coef_we in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_r[i] <= DATA_WIDTH'(i + 1);
      end
    end else if (coef_we && (int'(coef_idx) < N_TAPS)) begin
      coef_r[coef_idx] <= coef_data;
    end else begin
      coef_r <= coef_r;
    end
  end

  // Reload request: a new pulse wins over the clear at the end of a load, so none is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_pending_r <= 1'b0;
    end else if (coef_reload) begin
      reload_pending_r <= 1'b1;
    end else if (load_done_s) begin
      reload_pending_r <= 1'b0;
    end else begin
      reload_pending_r <= reload_pending_r;
    end
  end

  // Sticky error flag: a new timeout wins over err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  // Main sequencer: drives all bus signals and the stream handshake from registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_LOAD_COEFF;
      idx_r            <= '0;
      wait_cnt_r       <= 8'd0;
      adr_r            <= '0;
      dat_r            <= '0;
      we_r             <= 1'b0;
      stb_r            <= 1'b0;
      cyc_r            <= 1'b0;
      data_out_r       <= '0;
      data_out_valid_r <= 1'b0;
      data_in_ready_r  <= 1'b0;
      busy_r           <= 1'b1;
    end else begin
      data_out_valid_r <= 1'b0;
      case (state_r)
        ST_LOAD_COEFF: begin
          data_in_ready_r <= 1'b0;
          if (xfer_done_s) begin
            // An aborted index is simply skipped
            stb_r <= 1'b0;
            cyc_r <= 1'b0;
            we_r  <= 1'b0;
            if (idx_r == LAST_IDX_C) begin
              state_r <= ST_WAIT_INPUT;
              busy_r  <= 1'b0;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else if (!stb_r) begin
            // Strobe low here means the idle cycle after a transfer has elapsed
            adr_r <= ADDR_WIDTH'(idx_r);
            dat_r <= coef_r[idx_r];
            we_r  <= 1'b1;
            stb_r <= 1'b1;
            cyc_r <= 1'b1;
          end else begin
            stb_r <= stb_r;
          end
        end
        ST_WAIT_INPUT: begin
          if (reload_pending_r) begin
            state_r         <= ST_LOAD_COEFF;
            idx_r           <= '0;
            data_in_ready_r <= 1'b0;
            busy_r          <= 1'b1;
          end else if (data_in_valid && data_in_ready_r) begin
            adr_r           <= SAMPLE_ADR_C;
            dat_r           <= data_in;
            we_r            <= 1'b1;
            stb_r           <= 1'b1;
            cyc_r           <= 1'b1;
            data_in_ready_r <= 1'b0;
            state_r         <= ST_SEND_SAMPLE;
            busy_r          <= 1'b1;
          end else begin
            data_in_ready_r <= 1'b1;
          end
        end
        ST_SEND_SAMPLE: begin
          if (xfer_done_s) begin
            stb_r <= 1'b0;
            cyc_r <= 1'b0;
            we_r  <= 1'b0;
            if (timeout_s) begin
              state_r <= ST_WAIT_INPUT;
              busy_r  <= 1'b0;
            end else begin
              wait_cnt_r <= WAIT_LOAD_C;
              state_r    <= ST_WAIT_RESULT;
            end
          end else begin
            stb_r <= stb_r;
          end
        end
        ST_WAIT_RESULT: begin
          // Strobe rises on the edge that sees zero: WAIT_CYCLES+1 edges after the ack edge
          if (wait_cnt_r == 8'd0) begin
            adr_r   <= RESULT_ADR_C;
            we_r    <= 1'b0;
            stb_r   <= 1'b1;
            cyc_r   <= 1'b1;
            state_r <= ST_READ_RESULT;
          end else begin
            wait_cnt_r <= wait_cnt_r - 8'd1;
          end
        end
        ST_READ_RESULT: begin
          if (xfer_done_s) begin
            stb_r            <= 1'b0;
            cyc_r            <= 1'b0;
            we_r             <= 1'b0;
            data_out_r       <= timeout_s ? '0 : dat_i;
            data_out_valid_r <= 1'b1;
            state_r          <= ST_WAIT_INPUT;
            busy_r           <= 1'b0;
          end else begin
            stb_r <= stb_r;
          end
        end
        default: begin
          state_r         <= ST_LOAD_COEFF;
          idx_r           <= '0;
          stb_r           <= 1'b0;
          cyc_r           <= 1'b0;
          we_r            <= 1'b0;
          data_in_ready_r <= 1'b0;
          busy_r          <= 1'b1;
        end
      endcase
    end
  end

  assign adr_o          = adr_r;
  assign dat_o          = dat_r;
  assign we_o           = we_r;
  assign stb_o          = stb_r;
  assign cyc_o          = cyc_r;
  assign data_out       = data_out_r;
  assign data_out_valid = data_out_valid_r;
  assign data_in_ready  = data_in_ready_r;
  assign busy           = busy_r;
  assign err            = err_r;

endmodule

// File: tb/tb_fir_wb_master_param.sv
// Scoreboard bench for fir_wb_master_param. The stimulus process pushes the
// expected bus transfers and results. A negedge slave/monitor process answers
// the strobes, pops the expected entries and compares them.
module tb_fir_wb_master_param;

  localparam int NT = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int WC = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_idx = '0;
  logic [DW-1:0] coef_data = '0;
  logic          coef_reload = 1'b0;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          we_o;
  logic          stb_o;
  logic          cyc_o;
  logic          ack_i = 1'b0;

  always #5 clk = ~clk;

  fir_wb_master_param #(
    .N_TAPS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .WAIT_CYCLES(WC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .coef_reload(coef_reload), .busy(busy), .err(err), .err_clr(err_clr),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } bus_t;

  bus_t          exp_bus [$];
  logic [DW-1:0] exp_res [$];
  bus_t          cur;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            n_dov = 0;
  int            wack_cyc = 0;
  logic          prev_stb = 1'b0;
  logic          prev_dov = 1'b0;
  logic          no_ack = 1'b0;
  logic          hold_read = 1'b0;
  logic [DW-1:0] last_sample = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic push_w(input int adr, input int dat);
    bus_t b;
    b.we = 1'b1; b.adr = AW'(adr); b.dat = DW'(dat);
    exp_bus.push_back(b);
  endtask

  task automatic push_r();
    bus_t b;
    b.we = 1'b0; b.adr = AW'(NT + 1); b.dat = '0;
    exp_bus.push_back(b);
  endtask

  // Offer data_in until a negedge shows ready; returns at the negedge after the accepting edge
  task automatic feed_hold(input logic [DW-1:0] d);
    int n = 0;
    data_in = d;
    data_in_valid = 1'b1;
    while (!data_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 32'(data_in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic feed(input logic [DW-1:0] d);
    feed_hold(d);
    data_in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!data_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 32'(data_in_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_bus.size() != 0 || exp_res.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_bus.size() + exp_res.size()), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor: the slave acks every strobe one cycle after it sees it;
  // the monitor checks each acked transfer against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      ack_i = 1'b0;
      prev_stb = 1'b0;
      prev_dov = 1'b0;
    end else begin
      if (stb_o && !prev_stb && !we_o) chk("rd_gap", 32'(cyc - wack_cyc), 32'(WC + 1));
      prev_stb = stb_o;
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (stb_o && cyc_o && !no_ack && !(hold_read && !we_o)) begin
        ack_i = 1'b1;
        if (exp_bus.size() == 0) begin
          chk("bus_extra_adr", 32'(adr_o), 32'hFFFF_FFFF);
        end else begin
          cur = exp_bus.pop_front();
          chk("bus_we", 32'(we_o), 32'(cur.we));
          chk("bus_adr", 32'(adr_o), 32'(cur.adr));
          if (cur.we) chk("bus_dat", 32'(dat_o), 32'(cur.dat));
        end
        if (we_o && adr_o == AW'(NT)) begin
          last_sample = dat_o;
          wack_cyc = cyc + 1;
        end
        if (!we_o) dat_i = last_sample << 3;
      end
      if (data_out_valid) begin
        chk("dov_single", 32'(prev_dov), 32'd0);
        n_dov++;
        if (exp_res.size() == 0) chk("res_extra", 32'(data_out), 32'hFFFF_FFFF);
        else chk("data_out", 32'(data_out), 32'(exp_res.pop_front()));
      end
      prev_dov = data_out_valid;
    end
  end

  initial begin
    int base;
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_dov", 32'(data_out_valid), 32'd0);
    chk("rst_ready", 32'(data_in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Initial coefficient load 1..4
    push_w(0, 1); push_w(1, 2); push_w(2, 3); push_w(3, 4);
    rst = 1'b0;
    wait_ready();
    chk("load_done", 32'(exp_bus.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single sample 5 -> 0x28
    push_w(4, 16'h0005); push_r(); exp_res.push_back(16'h0028);
    feed(16'h0005);
    wait_drain();
    chk("dov_count1", 32'(n_dov), 32'd1);

    // Table write + reload during an in-flight sample; a second sample waits for the reload
    @(negedge clk);
    coef_we = 1'b1; coef_idx = 2'd2; coef_data = 16'h0010;
    @(negedge clk);
    coef_we = 1'b0;
    push_w(4, 16'h0007); push_r(); exp_res.push_back(16'h0038);
    push_w(0, 1); push_w(1, 2); push_w(2, 16'h0010); push_w(3, 4);
    push_w(4, 16'h0009); push_r(); exp_res.push_back(16'h0048);
    feed_hold(16'h0007);
    coef_reload = 1'b1;
    data_in = 16'h0009;
    @(negedge clk);
    coef_reload = 1'b0;
    feed(16'h0009);
    wait_drain();

    // Three samples with valid held high
    base = n_dov;
    push_w(4, 1); push_r(); exp_res.push_back(16'h0008);
    push_w(4, 2); push_r(); exp_res.push_back(16'h0010);
    push_w(4, 3); push_r(); exp_res.push_back(16'h0018);
    feed_hold(16'h0001);
    feed_hold(16'h0002);
    feed(16'h0003);
    wait_drain();
    chk("dov_count3", 32'(n_dov - base), 32'd3);

`ifdef FIR_WB_ACK_TIMEOUT_EN
    // Sample write never acked: strobe held TO cycles, err set, no result
    wait_ready();
    base = n_dov;
    no_ack = 1'b1;
    feed(16'h000B);
    n = 0;
    while (stb_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", 32'(n), 32'(TO));
    chk("to_err", 32'(err), 32'd1);
    no_ack = 1'b0;
    wait_ready();
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_no_out", 32'(n_dov - base), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
`else
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_idle", 32'(err), 32'd0);
`endif

    // Reset in the middle of a result read
    wait_ready();
    hold_read = 1'b1;
    push_w(4, 16'h000A);
    feed(16'h000A);
    n = 0;
    while (!(stb_o && !we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rd_seen", 32'(stb_o && !we_o), 32'd1);
    push_w(0, 1); push_w(1, 2); push_w(2, 3); push_w(3, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb", 32'(stb_o), 32'd0);
    chk("mid_rst_cyc", 32'(cyc_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    hold_read = 1'b0;
    wait_ready();
    wait_drain();
    chk("final_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
